fetch_buf: RTL

Instruction buffer between the fetch stage and decode. Accepts `{pc, pc4, inst}` triples from fetch with a valid/ready handshake, holds up to `DEPTH` entries in order, and presents the oldest entry to decode. Its `f_ready` is the fetch stall source: fetch is stopped whenever `f_ready` is low. A branch or jump redirect resolved in EX drives `flush`, which discards every wrong-path entry.

---
 rtl/fetch_buf_if.sv | 25 ++
 rtl/fetch_buf.sv | 83 ++++++++
 2 files changed

// File: rtl/fetch_buf_if.sv
// Fetch-to-decode handshake bundle for fetch_buf.
// master: fetch/decode environment side; slave: the buffer itself.
interface fetch_buf_if;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic [31:0] f_inst;
  logic        f_ready;
  logic        flush;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  logic [31:0] d_inst;
  logic        d_ready;

  modport master (
    output f_valid, f_pc, f_pc4, f_inst, flush, d_ready,
    input  f_ready, d_valid, d_pc, d_pc4, d_inst
  );

  modport slave (
    input  f_valid, f_pc, f_pc4, f_inst, flush, d_ready,
    output f_ready, d_valid, d_pc, d_pc4, d_inst
  );
endinterface

// File: rtl/fetch_buf.sv
// In-order fetch-to-decode instruction buffer with first-word fall-through.
// Optional FETCH_BUF_STATS_EN adds saturating stall/flush event counters.
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  fetch_buf_if.slave  bus
`ifdef FETCH_BUF_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign bus.f_ready = (count != FULL);
  assign bus.d_valid = (count != '0);
  assign push = bus.f_valid & bus.f_ready & ~bus.flush;
  assign pop  = bus.d_valid & bus.d_ready & ~bus.flush;

  always_comb begin
    bus.d_pc   = '0;
    bus.d_pc4  = '0;
    bus.d_inst = NOP;
    if (bus.d_valid) begin
      {bus.d_pc, bus.d_pc4, bus.d_inst} = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.f_pc, bus.f_pc4, bus.f_inst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FETCH_BUF_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.f_valid && !bus.f_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bus.flush && count != '0 && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif
endmodule
